spi_slave_param: RTL
====================

Name: spi_slave_param

Overview:
Parametrised SPI slave front-end for the single-port RAM subsystem. It deserialises MOSI frames of 2 command bits plus DATA_W payload bits, MSB first, one bit per clk while SS_n is low, and presents each completed frame on rx_data with a one-cycle rx_valid pulse. For read-data frames it waits, with a timeout, for tx_valid from the RAM and serialises tx_data on MISO. It tracks read-address/read-data pairing internally and flags aborted frames on frame_err.

Parameters:
DATA_W, 8, payload width in bits (min 2); rx_data is DATA_W+2 bits, tx_data is DATA_W bits.
TX_TIMEOUT, 16, max clk cycles spent in TX_WAIT before abort (min 1).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous active-high reset.
MOSI  input  1  serial data in; sampled every clk while SS_n is low.
SS_n  input  1  active-low slave select; high ends or aborts a frame.
tx_valid  input  1  tx_data is valid; sampled only in TX_WAIT.
tx_data  input  DATA_W  read data to serialise, MSB first.
MISO  output  1  serial data out; 0 whenever not in TX_SHIFT.
rx_valid  output  1  one-cycle pulse; rx_data holds a new frame.
rx_data  output  DATA_W+2  last completed frame, {cmd[1:0], payload}.
tx_busy  output  1  high in TX_WAIT and TX_SHIFT.
frame_err  output  1  one-cycle pulse on abort or timeout.

Behaviour:
- Reset (async, rst=1): state IDLE; MISO=0, rx_valid=0, rx_data=0, tx_busy=0, frame_err=0; read_pending=0; counters=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- IDLE: SS_n=0 -> CHK_CMD. No bit is sampled in this cycle.
- CHK_CMD: sample MOSI as frame bit DATA_W+1 (cmd[1]). MOSI=0 -> WRITE. MOSI=1 and read_pending=0 -> READ_ADD. MOSI=1 and read_pending=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift in the remaining DATA_W+1 bits into an internal register, MSB first. The frame spans DATA_W+2 sampled cycles, counting CHK_CMD.
- Frame completion: on the edge after the last bit is sampled, rx_data <= assembled frame and rx_valid=1 for exactly one cycle. rx_data is otherwise held and only updates on completed frames.
- After completion:
  - WRITE and READ_ADD -> DONE.
  - READ_DATA -> TX_WAIT.
  - If the completed frame has cmd==2'b10, set read_pending.
- rx_data is forwarded verbatim. The state choice affects only read_pending and tx handling, not rx_data contents.
- TX_WAIT: the timeout counter increments each cycle.
  - On tx_valid=1, capture tx_data, drive MISO=tx_data[DATA_W-1] on that edge, and go to TX_SHIFT.
  - If TX_TIMEOUT cycles elapse without tx_valid: frame_err pulse, go to DONE, read_pending unchanged.
- TX_SHIFT: each subsequent edge drives the next lower bit. Each bit is valid for one cycle, DATA_W cycles total. After bit 0's cycle, MISO <= 0, read_pending cleared, go to DONE.
- DONE: MOSI ignored; stays in DONE until SS_n=1 -> IDLE, with no error.
- SS_n=1 in CHK_CMD, WRITE, READ_ADD, READ_DATA (incomplete), TX_WAIT or TX_SHIFT:
  - Next state IDLE, frame_err pulse, no rx_valid, MISO <= 0.
  - read_pending unchanged.
  - Partial shift data discarded; rx_data unchanged.
- SS_n rising in the same cycle the last bit would be sampled: the bit is not sampled, and this is treated as an abort.
- tx_valid outside TX_WAIT is ignored.
- tx_busy is a registered decode of TX_WAIT|TX_SHIFT.
- Reset asserted mid-frame or mid-transmission returns everything to reset values immediately.

Test Plan:
- DATA_W=8, SS_n low, MOSI 10'b00_1010_0101 -> rx_valid one pulse 10 sampled cycles after CHK_CMD entry, rx_data=10'h0A5, MISO=0, frame_err=0.
- Frame 10'b10_0000_0011 then new SS_n frame 10'b11_xxxx_xxxx, tx_valid with tx_data=8'hC3 two cycles after rx_valid -> second frame routed to READ_DATA; MISO = 1,1,0,0,0,0,1,1 on consecutive cycles; tx_busy high throughout; read_pending then 0.
- Read-data frame with no tx_valid -> after 16 cycles in TX_WAIT: frame_err pulse, tx_busy=0, MISO=0; next cmd[1]=1 frame again goes to READ_DATA.
- SS_n raised after 5 bits of a write frame -> frame_err pulse, no rx_valid, rx_data keeps the previous value, next frame decodes normally.
- rst pulsed high during TX_SHIFT -> all outputs 0 asynchronously; next cmd[1]=1 frame goes to READ_ADD.
- DATA_W=16 -> 18-bit frame 18'h2ABCD captured exactly; tx_data=16'h8001 shifts out as 1, fourteen 0s, 1.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM: deserialises {cmd[1:0], payload} frames
// from MOSI, reports them on rx_data/rx_valid, and serialises RAM read data on MISO.
// Ports: clk/rst; MOSI, SS_n serial in; tx_valid/tx_data from the RAM; MISO serial out;
// rx_valid/rx_data frame out; tx_busy (waiting or shifting); frame_err (abort/timeout pulse).
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MOSI,
    input  logic              SS_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              tx_busy,
    output logic              frame_err
);

    localparam int FW = DATA_W + 2;
    localparam int CW = $clog2(FW + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    localparam logic [CW-1:0] RX_LAST  = CW'(FW - 1);
    localparam logic [CW-1:0] TX_LAST  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W:0]   shift_q, shift_d;     // frame bits collected so far
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;   // bits sampled in the current frame
    logic [DATA_W+1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q, miso_d;
    logic              tx_busy_q, tx_busy_d;
    logic              pend_q, pend_d;       // read address seen, read data not yet sent
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;     // remaining bits to serialise, MSB next
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rx_cnt_d    = rx_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = 1'b0;
        pend_d      = pend_q;
        tmo_d       = tmo_q;
        tx_sh_d     = tx_sh_q;
        tx_cnt_d    = tx_cnt_q;

        case (state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    shift_d  = {{DATA_W{1'b0}}, MOSI};
                    rx_cnt_d = CNT_ONE;
                    if (!MOSI)      state_d = WRITE;
                    else if (pend_q) state_d = READ_DATA;
                    else            state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                // A rising SS_n on what would be the last bit still aborts:
                // that bit is never sampled.
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (rx_cnt_q == RX_LAST) begin
                    rx_data_d  = {shift_q, MOSI};
                    rx_valid_d = 1'b1;
                    // shift_q[DATA_W:DATA_W-1] are cmd[1:0] of the finished frame
                    if (shift_q[DATA_W] && !shift_q[DATA_W-1]) pend_d = 1'b1;
                    tmo_d   = '0;
                    state_d = (state_q == READ_DATA) ? TX_WAIT : DONE;
                end else begin
                    shift_d  = {shift_q[DATA_W-1:0], MOSI};
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            TX_WAIT: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (tx_valid) begin
                    miso_d   = tx_data[DATA_W-1];
                    tx_sh_d  = tx_data << 1;
                    tx_cnt_d = '0;
                    state_d  = TX_SHIFT;
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            TX_SHIFT: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (tx_cnt_q == TX_LAST) begin
                    pend_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    miso_d   = tx_sh_q[DATA_W-1];
                    tx_sh_d  = tx_sh_q << 1;
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Decoded from the next state so tx_busy lines up with the state register.
        tx_busy_d = (state_d == TX_WAIT) || (state_d == TX_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            rx_cnt_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            tx_busy_q   <= 1'b0;
            pend_q      <= 1'b0;
            tmo_q       <= '0;
            tx_sh_q     <= '0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            tx_busy_q   <= tx_busy_d;
            pend_q      <= pend_d;
            tmo_q       <= tmo_d;
            tx_sh_q     <= tx_sh_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign MISO      = miso_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign tx_busy   = tx_busy_q;
    assign frame_err = frame_err_q;

endmodule
